pc_fetch_ctrl: RTL and testbench

//   Sequences the program counter and instruction fetch for the single-cycle core.

---
 rtl/pc_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter sequencer and instruction fetch handshake
module pc_fetch_ctrl #(
    parameter int             N        = 9,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             TMO      = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         halt,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    input  logic         imem_ack,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    output logic         inst_valid,
    output logic [N-1:0] pc,
    output logic [1:0]   state,
    output logic         err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    // Last un-acked count value before the watchdog fires; unused when TMO is 0.
    localparam logic [7:0] TMO_LAST = (TMO == 0) ? 8'd0 : 8'(TMO - 1);
    localparam bit         TMO_EN   = (TMO != 0);

    logic [1:0]   state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] pend_pc_q, pend_pc_d;
    logic         pend_redir_q, pend_redir_d;
    logic         pend_halt_q, pend_halt_d;
    logic [7:0]   tmo_cnt_q, tmo_cnt_d;

    // State register plus the fetch bookkeeping that travels with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_redir_q <= 1'b0;
            pend_halt_q  <= 1'b0;
            tmo_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_redir_q <= pend_redir_d;
            pend_halt_q  <= pend_halt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Next-state: halt beats run in IDLE; an ack ends the fetch; the watchdog traps in ERR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!halt && run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (halt || pend_halt_q) state_d = ST_IDLE;
                end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // PC / pending-request update: pc only moves on an ack so the request address stays stable.
    always_comb begin
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_redir_d = pend_redir_q;
        pend_halt_d  = pend_halt_q;
        tmo_cnt_d    = tmo_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect) pc_d = redirect_pc;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    tmo_cnt_d    = 8'd0;
                    pend_redir_d = 1'b0;
                    pend_halt_d  = 1'b0;
                    if (redirect)          pc_d = redirect_pc;
                    else if (pend_redir_q) pc_d = pend_pc_q;
                    else                   pc_d = pc_q + {{(N-1){1'b0}}, 1'b1};
                end else begin
                    if (redirect) begin
                        pend_redir_d = 1'b1;
                        pend_pc_d    = redirect_pc;
                    end
                    if (halt) pend_halt_d = 1'b1;
                    if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs are decodes of registered state; only inst_valid follows the ack combinationally.
    always_comb begin
        imem_req   = (state_q == ST_FETCH);
        err        = (state_q == ST_ERR);
        inst_valid = (state_q == ST_FETCH) && imem_ack;
        state      = state_q;
        pc         = pc_q;
        imem_addr  = pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst, run, halt, redirect, imem_ack;
    logic [8:0] redirect_pc;
    logic       imem_req, inst_valid, err;
    logic [8:0] imem_addr, pc;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    pc_fetch_ctrl #(.N(9), .RESET_PC(9'd0), .TMO(15)) dut (
        .clk(clk), .rst(rst), .run(run), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_ack(imem_ack), .imem_req(imem_req),
        .imem_addr(imem_addr), .inst_valid(inst_valid), .pc(pc), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fetch must match the next expected address.
    always @(negedge clk) begin
        if (inst_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected actual=%0h required=none", imem_addr);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if (imem_addr !== e) begin
                    errors++;
                    $display("FAIL fetch_addr actual=%0h required=%0h", imem_addr, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; run = 1'b0; halt = 1'b0; redirect = 1'b0;
        redirect_pc = 9'd0; imem_ack = 1'b0;
        step(); step();
        chk("rst_pc", pc, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_state", state, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", inst_valid, 0);
        rst = 1'b1;

        // back-to-back fetch with ack tied high
        run = 1'b1; imem_ack = 1'b1;
        sb.push_back(9'd0); sb.push_back(9'd1); sb.push_back(9'd2); sb.push_back(9'd3);
        repeat (5) step();
        imem_ack = 1'b0; run = 1'b0;
        chk("b2b_pc", pc, 4);
        chk("run_low_stays_fetch", state, 1);

        // wait at pc=5 with a pending redirect
        imem_ack = 1'b1; sb.push_back(9'd4);
        step();
        imem_ack = 1'b0;
        chk("wait_addr1", imem_addr, 5);
        step();
        redirect = 1'b1; redirect_pc = 9'h040;
        chk("wait_addr2", imem_addr, 5);
        step();
        redirect = 1'b0;
        chk("wait_addr3", imem_addr, 5);
        chk("wait_req", imem_req, 1);
        step();
        imem_ack = 1'b1; sb.push_back(9'd5);
        step();
        chk("pend_redir_pc", pc, 9'h040);
        sb.push_back(9'h040);
        step();
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 9'h040;
        step();
        redirect = 1'b0;
        step();
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 9'h080; sb.push_back(9'h041);
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("override_pc", pc, 9'h080);

        // wrap from 1FF to 0
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 9'h1FF; sb.push_back(9'h080);
        step();
        redirect = 1'b0; sb.push_back(9'h1FF);
        chk("pre_wrap_pc", pc, 9'h1FF);
        step();
        imem_ack = 1'b0;
        chk("wrap_pc", pc, 0);
        chk("wrap_err", err, 0);

        // halt pulse while waiting at pc=7
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 9'd7; sb.push_back(9'd0);
        step();
        redirect = 1'b0; imem_ack = 1'b0; halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_wait_state", state, 1);
        step();
        imem_ack = 1'b1; sb.push_back(9'd7);
        step();
        imem_ack = 1'b0;
        chk("halt_state", state, 0);
        chk("halt_pc", pc, 8);
        chk("halt_req", imem_req, 0);
        halt = 1'b1; run = 1'b1;
        step(); step();
        chk("halt_run_idle", state, 0);
        halt = 1'b0;

        // timeout: ack never arrives
        step();
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("tmo_fetch_%0d", i), state, 1);
            step();
        end
        chk("tmo_state", state, 2);
        chk("tmo_err", err, 1);
        chk("tmo_req", imem_req, 0);
        chk("tmo_pc", pc, 8);
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 9'h033;
        step(); step();
        chk("err_sticky_state", state, 2);
        chk("err_frozen_pc", pc, 8);
        imem_ack = 1'b0; redirect = 1'b0; run = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("err_rst_state", state, 0);
        chk("err_rst_pc", pc, 0);
        chk("err_rst_err", err, 0);
        step();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
